// File: rtl/tone_period_decoder_if.sv
// Tone decoder bus: the incoming tone plus the measured period and decoded note.
// The decoder sits on the slave side. The tone source and consumer sit on the master side.
interface tone_period_decoder_if #(
    parameter int CNT_W = 32
);
    logic             tone_in;
    logic [CNT_W-1:0] period;
    logic             period_strobe;
    logic [2:0]       note;
    logic             note_valid;
    logic             no_signal;

    modport master (
        output tone_in,
        input  period,
        input  period_strobe,
        input  note,
        input  note_valid,
        input  no_signal
    );

    modport slave (
        input  tone_in,
        output period,
        output period_strobe,
        output note,
        output note_valid,
        output no_signal
    );
endinterface

// File: rtl/tone_period_decoder.sv
// Tone period decoder: measures the rise-to-rise period of a square-wave tone in
// clk cycles, maps it back to a 3-bit note code with a +/-TOL window, and only
// accepts a new note after CONFIRM consecutive matching periods.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   WAIT_EDGE | no reference edge yet (after reset or timeout); next rise arms
//   MEASURE   | counting from the last rise; each rise yields a period
module tone_period_decoder #(
    parameter int CNT_W   = 32,
    parameter int TOL     = 512,
    parameter int CONFIRM = 2,
    parameter int TIMEOUT = 200000
) (
    input logic                  clk,
    input logic                  reset,
    tone_period_decoder_if.slave bus
);

    typedef enum logic {
        WAIT_EDGE = 1'b0,
        MEASURE   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);
    localparam logic [2:0]       CONFIRM_C = 3'(CONFIRM);

    // Full tone periods (generator divide counts) for codes 000..111.
    function automatic logic [CNT_W:0] nominal(input logic [2:0] code);
        case (code)
            3'd0:    nominal = (CNT_W+1)'(95600);
            3'd1:    nominal = (CNT_W+1)'(85180);
            3'd2:    nominal = (CNT_W+1)'(75870);
            3'd3:    nominal = (CNT_W+1)'(71630);
            3'd4:    nominal = (CNT_W+1)'(63860);
            3'd5:    nominal = (CNT_W+1)'(56820);
            3'd6:    nominal = (CNT_W+1)'(50660);
            default: nominal = (CNT_W+1)'(47800);
        endcase
    endfunction

    logic             sync1_q;
    logic             sync2_q;
    logic             hist_q;
    logic             rise;

    state_t           state_q;
    logic [CNT_W-1:0] counter_q;
    logic [CNT_W-1:0] period_q;
    logic             strobe_q;
    logic [2:0]       note_q;
    logic             valid_q;
    logic             no_sig_q;
    logic [2:0]       cand_q;
    logic [2:0]       cnt_q;

    logic [2:0]       cand_d;
    logic [2:0]       cnt_d;

    logic             match_hit;
    logic [2:0]       match_code;
    logic [CNT_W:0]   period_ext;
    logic [CNT_W:0]   nom;
    logic [CNT_W:0]   diff;

    // Two-stage synchronizer on the asynchronous tone, plus one history stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= bus.tone_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~hist_q;

    // Window match of the last period against every nominal; differences are one bit wider so they never wrap.
    always_comb begin
        match_hit  = 1'b0;
        match_code = 3'd0;
        period_ext = {1'b0, period_q};
        nom        = '0;
        diff       = '0;
        for (int i = 0; i < 8; i++) begin
            nom  = nominal(3'(i));
            diff = (period_ext >= nom) ? (period_ext - nom) : (nom - period_ext);
            if (diff <= TOL_C) begin
                match_hit  = 1'b1;
                match_code = 3'(i);
            end
        end
    end

    // Next candidate and confirm count for a matching decode; a new code restarts the count at one.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (match_code == cand_q) begin
            cnt_d = (cnt_q >= CONFIRM_C) ? CONFIRM_C : (cnt_q + 3'd1);
        end else begin
            cand_d = match_code;
            cnt_d  = 3'd1;
        end
    end

    // Measurement FSM, period counter, note confirmation and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WAIT_EDGE;
            counter_q <= '0;
            period_q  <= '0;
            strobe_q  <= 1'b0;
            note_q    <= 3'd0;
            valid_q   <= 1'b0;
            no_sig_q  <= 1'b1;
            cand_q    <= 3'd0;
            cnt_q     <= 3'd0;
        end else begin
            strobe_q <= 1'b0;
            if (counter_q != TIMEOUT_C) begin
                counter_q <= counter_q + ONE_C;
            end

            // Decode runs the cycle after a new period lands; the old note is kept while a new one confirms.
            if (strobe_q) begin
                if (match_hit) begin
                    cand_q <= cand_d;
                    cnt_q  <= cnt_d;
                    if (cnt_d == CONFIRM_C) begin
                        note_q  <= cand_d;
                        valid_q <= 1'b1;
                    end
                end else begin
                    valid_q <= 1'b0;
                    cnt_q   <= 3'd0;
                end
            end

            case (state_q)
                WAIT_EDGE: begin
                    if (rise) begin
                        state_q   <= MEASURE;
                        counter_q <= ONE_C;
                    end
                end
                MEASURE: begin
                    // A rise wins over a timeout landing in the same cycle.
                    if (rise) begin
                        period_q  <= counter_q;
                        strobe_q  <= 1'b1;
                        counter_q <= ONE_C;
                        no_sig_q  <= 1'b0;
                    end else if (counter_q == TIMEOUT_C) begin
                        state_q  <= WAIT_EDGE;
                        no_sig_q <= 1'b1;
                        valid_q  <= 1'b0;
                        cnt_q    <= 3'd0;
                    end
                end
                default: state_q <= WAIT_EDGE;
            endcase
        end
    end

    assign bus.period        = period_q;
    assign bus.period_strobe = strobe_q;
    assign bus.note          = note_q;
    assign bus.note_valid    = valid_q;
    assign bus.no_signal     = no_sig_q;

endmodule

// File: tb/tb_tone_period_decoder.sv
// Directed bench for tone_period_decoder: drives tone periods of known length
// and checks period, strobe, note and status against hand-computed values.
module tb_tone_period_decoder;

    localparam int CNT_W = 32;
    localparam int TO    = 100000;

    logic clk;
    logic reset;

    int n_checks;
    int n_fail;

    logic [31:0] s_period;
    logic        s_strobe;
    logic        s_nosig;
    logic [2:0]  s_note;
    logic        s_valid;
    logic        s_strobe2;

    tone_period_decoder_if #(.CNT_W(CNT_W)) bus ();

    tone_period_decoder #(
        .CNT_W  (CNT_W),
        .TOL    (512),
        .CONFIRM(2),
        .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Wait n clock edges, then settle just after the last one.
    task automatic low(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise the tone for hi edges, sampling outputs at the strobe slot and the note slot.
    task automatic rise(input int hi);
        bus.tone_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        s_strobe = bus.period_strobe;
        s_period = bus.period;
        s_nosig  = bus.no_signal;
        @(posedge clk);
        #1;
        s_note    = bus.note;
        s_valid   = bus.note_valid;
        s_strobe2 = bus.period_strobe;
        repeat (hi - 4) @(posedge clk);
        #1;
        bus.tone_in = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.tone_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_period", bus.period, 0);
        chk("rst_strobe", bus.period_strobe, 0);
        chk("rst_note", bus.note, 0);
        chk("rst_valid", bus.note_valid, 0);
        chk("rst_nosig", bus.no_signal, 1);
        reset = 1'b0;
        low(10);

        // 95600 tone
        rise(47800);
        chk("e1_strobe", s_strobe, 0);
        chk("e1_nosig", s_nosig, 1);
        low(47800);
        rise(47800);
        chk("e2_strobe", s_strobe, 1);
        chk("e2_period", s_period, 95600);
        chk("e2_nosig", s_nosig, 0);
        chk("e2_valid", s_valid, 0);
        chk("e2_strobe_1cyc", s_strobe2, 0);
        low(47800);
        rise(47800);
        chk("e3_period", s_period, 95600);
        chk("e3_note", s_note, 0);
        chk("e3_valid", s_valid, 1);
        low(47800);

        // switch to 47800
        rise(23900);
        chk("e4_period", s_period, 95600);
        chk("e4_note", s_note, 0);
        low(23900);
        rise(23900);
        chk("e5_period", s_period, 47800);
        chk("e5_note_hold", s_note, 0);
        chk("e5_valid", s_valid, 1);
        low(23900);
        rise(35815);
        chk("e6_period", s_period, 47800);
        chk("e6_note", s_note, 7);
        chk("e6_valid", s_valid, 1);
        low(35815);

        // 71630 tone and tolerance edges
        rise(35815);
        chk("e7_period", s_period, 71630);
        chk("e7_note_hold", s_note, 7);
        low(35815);
        rise(36071);
        chk("e8_note", s_note, 3);
        chk("e8_valid", s_valid, 1);
        low(36071);
        rise(35559);
        chk("e9_period", s_period, 72142);
        chk("e9_note", s_note, 3);
        chk("e9_valid", s_valid, 1);
        low(35559);
        rise(36071);
        chk("e10_period", s_period, 71118);
        chk("e10_valid", s_valid, 1);
        low(36072);
        rise(35815);
        chk("e11_strobe", s_strobe, 1);
        chk("e11_period", s_period, 72143);
        chk("e11_valid", s_valid, 0);
        chk("e11_note", s_note, 3);
        low(35815);
        rise(35815);
        chk("e12_period", s_period, 71630);
        chk("e12_valid", s_valid, 0);
        low(35815);
        rise(35815);
        chk("e13_valid", s_valid, 1);
        chk("e13_note", s_note, 3);

        // hold low until timeout
        low(TO + 2 - 35815);
        chk("to_pre_nosig", bus.no_signal, 0);
        chk("to_pre_valid", bus.note_valid, 1);
        low(1);
        chk("to_nosig", bus.no_signal, 1);
        chk("to_valid", bus.note_valid, 0);
        chk("to_note", bus.note, 3);
        low(100);

        // restart with 63860
        rise(31930);
        chk("f1_strobe", s_strobe, 0);
        chk("f1_nosig", s_nosig, 1);
        low(31930);
        rise(31930);
        chk("f2_strobe", s_strobe, 1);
        chk("f2_period", s_period, 63860);
        chk("f2_nosig", s_nosig, 0);
        chk("f2_valid", s_valid, 0);
        low(31930);
        rise(31930);
        chk("f3_note", s_note, 4);
        chk("f3_valid", s_valid, 1);
        low(31930);
        rise(30000);
        chk("f4_valid", s_valid, 1);
        low(30000);

        // off-table period
        rise(31930);
        chk("f5_strobe", s_strobe, 1);
        chk("f5_period", s_period, 60000);
        chk("f5_valid", s_valid, 0);
        chk("f5_note", s_note, 4);
        low(31930);
        rise(31930);
        chk("f6_valid", s_valid, 0);
        low(31930);
        rise(31930);
        chk("f7_valid", s_valid, 1);
        chk("f7_note", s_note, 4);

        // reset mid-period
        low(10000);
        reset = 1'b1;
        low(1);
        chk("mr_period", bus.period, 0);
        chk("mr_note", bus.note, 0);
        chk("mr_valid", bus.note_valid, 0);
        chk("mr_nosig", bus.no_signal, 1);
        reset = 1'b0;
        low(5000);
        rise(31930);
        chk("g1_strobe", s_strobe, 0);
        chk("g1_nosig", s_nosig, 1);
        low(31930);
        rise(31930);
        chk("g2_strobe", s_strobe, 1);
        chk("g2_period", s_period, 63860);
        chk("g2_nosig", s_nosig, 0);
        low(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
